// File: rtl/imem_prog.sv
// Loadable instruction memory: one-cycle registered fetch port plus a byte-serial
// program-load port that packs big-endian words and stalls fetch while loading.
module imem_prog #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [31:0]       fetch_rdata,
    output logic              fetch_valid,
    output logic              fetch_misaligned,
    input  logic              ld_start,
    input  logic [ADDR_W-3:0] ld_base,
    input  logic              ld_byte_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_done,
    output logic              ld_ready,
    output logic              busy,
    output logic [ADDR_W-2:0] ld_count
);

    localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);
    localparam logic [ADDR_W-2:0] CNT_MAX = (ADDR_W - 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Power-up contents are zero; rst deliberately leaves the array alone.
    logic [31:0] r_mem [DEPTH] = '{default: 32'h0};

    logic [1:0]        r_state;
    logic [ADDR_W-3:0] r_wp;
    logic [1:0]        r_bi;
    logic [31:0]       r_asm;
    logic [ADDR_W-2:0] r_count;

    logic [31:0]       w_asm;
    logic              w_accept;
    logic [1:0]        w_bi_next;
    logic              w_we;
    logic [31:0]       w_wdata;
    logic [ADDR_W-2:0] w_count_inc;

    assign ld_ready = (r_state == ST_LOAD);
    assign busy     = (r_state != ST_IDLE);
    assign ld_count = r_count;

    assign w_accept    = (r_state == ST_LOAD) && ld_byte_valid;
    assign w_bi_next   = w_accept ? r_bi + 2'd1 : r_bi;
    assign w_count_inc = (r_count == CNT_MAX) ? r_count : r_count + 1'b1;

    always_comb begin
        w_asm = r_asm;
        case (r_bi)
            2'd0:    w_asm[31:24] = ld_byte;
            2'd1:    w_asm[23:16] = ld_byte;
            2'd2:    w_asm[15:8]  = ld_byte;
            default: w_asm[7:0]   = ld_byte;
        endcase
    end

    assign w_we    = (w_accept && (r_bi == 2'd3)) || (r_state == ST_FLUSH);
    assign w_wdata = (r_state == ST_FLUSH) ? r_asm : w_asm;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wp] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_wp    <= '0;
            r_bi    <= 2'd0;
            r_asm   <= 32'h0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ld_start) begin
                        r_state <= ST_LOAD;
                        r_wp    <= ld_base;
                        r_bi    <= 2'd0;
                        r_asm   <= 32'h0;
                        r_count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_bi <= w_bi_next;
                        if (r_bi == 2'd3) begin
                            r_wp    <= r_wp + 1'b1;
                            r_count <= w_count_inc;
                            r_asm   <= 32'h0;
                        end else begin
                            r_asm <= w_asm;
                        end
                    end
                    // A byte accepted in the ld_done cycle counts before deciding on FLUSH.
                    if (ld_done) begin
                        r_state <= (w_bi_next != 2'd0) ? ST_FLUSH : ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_IDLE;
                    r_wp    <= r_wp + 1'b1;
                    r_count <= w_count_inc;
                    r_bi    <= 2'd0;
                    r_asm   <= 32'h0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_rdata      <= 32'h0;
            fetch_valid      <= 1'b0;
            fetch_misaligned <= 1'b0;
        end else if ((r_state == ST_IDLE) && fetch_en) begin
            fetch_rdata      <= r_mem[fetch_addr[ADDR_W-1:2]];
            fetch_valid      <= 1'b1;
            fetch_misaligned <= (fetch_addr[1:0] != 2'b00);
        end else begin
            fetch_valid      <= 1'b0;
            fetch_misaligned <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_prog.sv
// Bench for imem_prog: fetch results are checked by a scoreboard monitor, load
// control outputs by directed checks in the stimulus thread.
module tb_imem_prog;

    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fetch_en = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic [31:0]       fetch_rdata;
    logic              fetch_valid;
    logic              fetch_misaligned;
    logic              ld_start = 1'b0;
    logic [ADDR_W-3:0] ld_base = '0;
    logic              ld_byte_valid = 1'b0;
    logic [7:0]        ld_byte = '0;
    logic              ld_done = 1'b0;
    logic              ld_ready;
    logic              busy;
    logic [ADDR_W-2:0] ld_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] exp_q[$];

    imem_prog #(.ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_en         (fetch_en),
        .fetch_addr       (fetch_addr),
        .fetch_rdata      (fetch_rdata),
        .fetch_valid      (fetch_valid),
        .fetch_misaligned (fetch_misaligned),
        .ld_start         (ld_start),
        .ld_base          (ld_base),
        .ld_byte_valid    (ld_byte_valid),
        .ld_byte          (ld_byte),
        .ld_done          (ld_done),
        .ld_ready         (ld_ready),
        .busy             (busy),
        .ld_count         (ld_count)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every valid fetch result must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && fetch_valid) begin
            logic [32:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fetch_unexpected: got data=%h mis=%b, required no result",
                         fetch_rdata, fetch_misaligned);
            end else begin
                e = exp_q.pop_front();
                if ({fetch_misaligned, fetch_rdata} !== e) begin
                    n_fail++;
                    $display("FAIL fetch_result: got data=%h mis=%b, required data=%h mis=%b",
                             fetch_rdata, fetch_misaligned, e[31:0], e[32]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic fetch(input logic [7:0] addr, input logic [31:0] data, input logic mis);
        fetch_en   = 1'b1;
        fetch_addr = addr;
        exp_q.push_back({mis, data});
        tick();
        fetch_en = 1'b0;
    endtask

    task automatic start(input logic [5:0] base);
        ld_start = 1'b1;
        ld_base  = base;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic done);
        ld_byte_valid = 1'b1;
        ld_byte       = b;
        ld_done       = done;
        tick();
        ld_byte_valid = 1'b0;
        ld_done       = 1'b0;
    endtask

    task automatic finish_load();
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
    endtask

    initial begin
        logic [7:0] prog [8];
        logic [7:0] wrap [8];
        logic [7:0] sess [4];
        prog = '{8'h20, 8'h08, 8'h00, 8'h17, 8'h21, 8'h09, 8'h00, 8'h2D};
        wrap = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
        sess = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_rdata", fetch_rdata, 32'h0);
        check("rst_valid", {31'h0, fetch_valid}, 32'h0);
        check("rst_mis", {31'h0, fetch_misaligned}, 32'h0);
        check("rst_ready", {31'h0, ld_ready}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_count", {25'h0, ld_count}, 32'h0);
        fetch(8'h00, 32'h0, 1'b0);
        tick();

        // Two full words from base 2
        start(6'd2);
        check("load_busy", {31'h0, busy}, 32'h1);
        check("load_ready", {31'h0, ld_ready}, 32'h1);
        for (int i = 0; i < 8; i++) send(prog[i], 1'b0);
        finish_load();
        check("load_done_busy", {31'h0, busy}, 32'h0);
        check("load_count", {25'h0, ld_count}, 32'd2);
        fetch(8'h08, 32'h20080017, 1'b0);
        fetch(8'h0C, 32'h2109002D, 1'b0);
        tick();

        // Partial word with ld_done on the last byte -> one FLUSH cycle
        start(6'd5);
        send(8'hAC, 1'b0);
        send(8'h09, 1'b1);
        check("flush_busy", {31'h0, busy}, 32'h1);
        check("flush_ready", {31'h0, ld_ready}, 32'h0);
        check("flush_count_pre", {25'h0, ld_count}, 32'd0);
        tick();
        check("flush_idle", {31'h0, busy}, 32'h0);
        check("flush_count", {25'h0, ld_count}, 32'd1);
        fetch(8'h14, 32'hAC090000, 1'b0);
        tick();

        // fetch_en held high across a whole load session
        fetch_en   = 1'b1;
        fetch_addr = 8'h08;
        ld_start   = 1'b1;
        ld_base    = 6'd10;
        exp_q.push_back({1'b0, 32'h20080017});
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(sess[i], 1'b0);
            check("stall_valid", {31'h0, fetch_valid}, 32'h0);
            check("stall_rdata", fetch_rdata, 32'h20080017);
        end
        fetch_addr = 8'h28;
        finish_load();
        check("stall_valid_done", {31'h0, fetch_valid}, 32'h0);
        check("stall_busy_drop", {31'h0, busy}, 32'h0);
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        tick();
        fetch_en = 1'b0;
        check("resume_valid", {31'h0, fetch_valid}, 32'h1);
        tick();

        // Wrap-around from the last word
        start(6'd63);
        for (int i = 0; i < 8; i++) send(wrap[i], 1'b0);
        finish_load();
        check("wrap_count", {25'h0, ld_count}, 32'd2);
        fetch(8'hFC, 32'h11111111, 1'b0);
        fetch(8'h03, 32'h22222222, 1'b1);
        tick();

        // Asynchronous reset in the middle of a load
        start(6'd0);
        for (int i = 0; i < 6; i++) send(8'(i + 1), 1'b0);
        rst = 1'b1;
        #2;
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_ready", {31'h0, ld_ready}, 32'h0);
        check("mid_rst_count", {25'h0, ld_count}, 32'h0);
        check("mid_rst_rdata", fetch_rdata, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_busy", {31'h0, busy}, 32'h0);
        fetch(8'h00, 32'h01020304, 1'b0);
        fetch(8'h04, 32'h00000000, 1'b0);
        repeat (2) tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_prog.md
# imem_prog

Parametrised, loadable instruction memory for the pipelined CPU: a synchronous one-cycle fetch port for the IF stage plus a byte-serial program-load port.
- The load port lets a host or UART loader write machine code at run time instead of relying on fixed initial contents.
- A small load state machine assembles bytes into big-endian 32-bit words and stalls fetch while a load is in progress.

## Interface
- ADDR_W, default 8: byte-address width; depth DEPTH = 2^(ADDR_W-2) words (default 64).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- fetch_en  in  1  fetch request this cycle
- fetch_addr  in  ADDR_W  byte address of the instruction
- fetch_rdata  out  32  registered instruction word
- fetch_valid  out  1  fetch_rdata holds the result of last cycle's request
- fetch_misaligned  out  1  that request had fetch_addr[1:0] != 0
- ld_start  in  1  begin a load session
- ld_base  in  ADDR_W-2  starting word index, sampled on ld_start
- ld_byte_valid  in  1  ld_byte is presented
- ld_byte  in  8  program byte, most-significant byte of each word first
- ld_done  in  1  end of load session
- ld_ready  out  1  bytes are accepted this cycle
- busy  out  1  load session or flush in progress
- ld_count  out  ADDR_W-1  words written since the last ld_start, saturating at DEPTH

## Operation
- Memory: DEPTH x 32 bits, zero at time 0, not cleared by rst.
- States: IDLE, LOAD, FLUSH.
- IDLE:
  - ld_start -> LOAD.
  - Sample ld_base into the write pointer wp; clear ld_count, the byte index bi (2 bits) and the assembly register.
- LOAD: ld_ready = 1, busy = 1.
  - Each ld_byte_valid writes ld_byte into lane 3-bi (bi=0 -> bits 31:24), then bi++.
  - On the 4th byte (bi==3), write the completed word to mem[wp], wp++ wrapping modulo DEPTH, ld_count++ (saturating), bi -> 0.
  - ld_start while in LOAD is ignored.
- ld_done in LOAD:
  - If ld_byte_valid is asserted in the same cycle, that byte is accepted first.
  - If bi != 0 after acceptance -> FLUSH; otherwise -> IDLE.
- FLUSH (1 cycle): unfilled low lanes are zero; write the partial word to mem[wp], ld_count++, -> IDLE. ld_ready = 0, busy = 1.
- Fetch:
  - In IDLE with fetch_en: fetch_rdata <= mem[fetch_addr[ADDR_W-1:2]], fetch_valid <= 1, fetch_misaligned <= (fetch_addr[1:0] != 0).
  - The word is still returned on a misaligned request; the low address bits are ignored.
- Fetch blocked: with busy = 1 or fetch_en = 0, fetch_valid <= 0 and fetch_misaligned <= 0. fetch_rdata holds its value.
- No read/write hazard exists because fetch is blocked whenever writes can occur.
- rst (any state):
  - State -> IDLE; fetch_rdata = 0, fetch_valid = 0, fetch_misaligned = 0, ld_ready = 0, busy = 0, ld_count = 0, bi = 0, wp = 0.
  - A partially assembled word is discarded; words already written remain.

## Timing
- Fetch latency: 1 cycle. A request at edge N produces a result valid after edge N+1; back-to-back requests give one result per cycle.
- ld_ready and busy are decoded from the state register, so they assert the cycle after ld_start is sampled.
- Word write occurs on the edge that accepts the 4th byte; a fetch issued in the first IDLE cycle after LOAD/FLUSH sees the new data.
- FLUSH adds exactly 1 cycle of busy after ld_done with a partial word.
- Fetch stall window: from the cycle after ld_start through the last LOAD/FLUSH cycle.
- Wrap-around: after writing word DEPTH-1, wp = 0 and subsequent words overwrite from index 0; ld_count saturates at DEPTH.

## Test plan
- Reset then fetch addr 0x00 -> after 1 cycle fetch_valid=1, fetch_rdata=0x00000000, fetch_misaligned=0; before the fetch, all outputs are 0.
- ld_start, ld_base=2, bytes 20 08 00 17 21 09 00 2D, ld_done -> mem[2]=0x20080017, mem[3]=0x2109002D, ld_count=2; fetch 0x08 -> 0x20080017, fetch 0x0C -> 0x2109002D.
- Partial flush: ld_base=5, bytes AC 09 with ld_done asserted together with the 2nd byte -> one FLUSH cycle with busy=1, then mem[5]=0xAC090000, ld_count=1.
- Fetch during load: fetch_en=1 every cycle across a load session -> fetch_valid=0 for the whole stall window and fetch_rdata unchanged; fetch_valid returns 1 one cycle after busy drops.
- Wrap: ld_base=DEPTH-1 (63), 8 bytes 11111111 22222222 -> mem[63]=0x11111111, mem[0]=0x22222222; fetch 0x03 -> 0x22222222 with fetch_misaligned=1.
- Reset mid-load after 6 bytes from ld_base=0 -> mem[0] updated, mem[1] unchanged, state IDLE, ld_ready=0, ld_count=0; the next fetch works normally.
